// File: rtl/op_sweep_ctrl.sv
// Sweeps the four 2-bit logic ops over latched operands, compares each result with d,
// and reports pass mask/count and best op. Optional per-op result log: OP_SWEEP_RESULT_LOG_EN.
module op_sweep_ctrl #(
   parameter int NUM_OPS = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [1:0]         a,
   input  logic [1:0]         b,
   input  logic [1:0]         c,
   input  logic [1:0]         d,
   output logic               busy,
   output logic               done,
   output logic [1:0]         op_cur,
   output logic [NUM_OPS-1:0] pass_mask,
   output logic [2:0]         pass_count,
   output logic [1:0]         best_op,
   output logic [7:0]         results
);

   // state | meaning
   // IDLE  | waiting for start; result outputs hold
   // RUN   | evaluating op idx, one op per cycle
   // DONE  | one-cycle done pulse, results final
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t     state, state_nxt;
   logic [1:0] a_q, b_q, c_q, d_q;
   logic [1:0] idx;
   logic [1:0] best_val;
   logic [1:0] r_cur;
   logic       pass_cur;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN: begin
            if (abort)            state_nxt = IDLE;
            else if (idx == 2'd3) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      r_cur = 2'b00;
      case (idx)
         2'd0: r_cur = ~(a_q & b_q & c_q);
         2'd1: r_cur = a_q & b_q & c_q;
         2'd2: r_cur = ~(a_q | b_q | c_q);
         2'd3: r_cur = a_q | b_q | c_q;
         default: r_cur = 2'b00;
      endcase
      pass_cur = (r_cur >= d_q);
   end

   assign busy   = (state == RUN);
   assign done   = (state == DONE);
   assign op_cur = busy ? idx : 2'd0;

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q        <= '0;
         b_q        <= '0;
         c_q        <= '0;
         d_q        <= '0;
         idx        <= '0;
         pass_mask  <= '0;
         pass_count <= '0;
         best_op    <= '0;
         best_val   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_q        <= a;
                  b_q        <= b;
                  c_q        <= c;
                  d_q        <= d;
                  idx        <= '0;
                  pass_mask  <= '0;
                  pass_count <= '0;
                  best_op    <= '0;
                  best_val   <= '0;
               end
            end
            RUN: begin
               if (abort) begin
                  idx        <= '0;
                  pass_mask  <= '0;
                  pass_count <= '0;
                  best_op    <= '0;
                  best_val   <= '0;
               end else begin
                  pass_mask[idx] <= pass_cur;
                  if (pass_cur) pass_count <= pass_count + 3'd1;
                  // op0 seeds the running best; later ops must beat it strictly
                  if (idx == 2'd0 || r_cur > best_val) begin
                     best_val <= r_cur;
                     best_op  <= idx;
                  end
                  idx <= idx + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef OP_SWEEP_RESULT_LOG_EN
   logic [7:0] results_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         results_q <= '0;
      end else begin
         case (state)
            IDLE: if (start) results_q <= '0;
            RUN: begin
               if (abort) results_q <= '0;
               else       results_q[{idx, 1'b0} +: 2] <= r_cur;
            end
            default: ;
         endcase
      end
   end

   assign results = results_q;
`else
   assign results = 8'h00;
`endif

endmodule

// File: tb/tb_op_sweep_ctrl.sv
// Scoreboard bench for op_sweep_ctrl: expected sweep outcomes are queued at start,
// a monitor pops and compares them on every done pulse.
module tb_op_sweep_ctrl;

   logic       clk = 1'b0;
   logic       rst, start, abort;
   logic [1:0] a, b, c, d;
   logic       busy, done;
   logic [1:0] op_cur;
   logic [3:0] pass_mask;
   logic [2:0] pass_count;
   logic [1:0] best_op;
   logic [7:0] results;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] mask;
      logic [2:0] cnt;
      logic [1:0] best;
      logic [7:0] res;
   } exp_t;

   exp_t sb[$];

   op_sweep_ctrl #(.NUM_OPS(4)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .a(a), .b(b), .c(c), .d(d),
      .busy(busy), .done(done), .op_cur(op_cur),
      .pass_mask(pass_mask), .pass_count(pass_count),
      .best_op(best_op), .results(results)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] op_fn(input int i, input logic [1:0] x, y, z);
      case (i)
         0:       return ~(x & y & z);
         1:       return x & y & z;
         2:       return ~(x | y | z);
         default: return x | y | z;
      endcase
   endfunction

   function automatic exp_t model(input logic [1:0] x, y, z, th);
      exp_t e;
      logic [1:0] r [4];
      int cnt = 0;
      int bi = 0;
      e.mask = '0;
      e.res  = '0;
      for (int i = 0; i < 4; i++) begin
         r[i] = op_fn(i, x, y, z);
         if (r[i] >= th) begin
            e.mask[i] = 1'b1;
            cnt++;
         end
      end
      for (int i = 1; i < 4; i++)
         if (r[i] > r[bi]) bi = i;
      e.cnt  = 3'(cnt);
      e.best = 2'(bi);
`ifdef OP_SWEEP_RESULT_LOG_EN
      e.res = {r[3], r[2], r[1], r[0]};
`endif
      return e;
   endfunction

   // monitor: every done pulse must match the oldest queued sweep
   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("pass_mask", pass_mask, e.mask);
            chk("pass_count", pass_count, e.cnt);
            chk("best_op", best_op, e.best);
            chk("results", results, e.res);
         end
      end
   end

   task automatic run_sweep(input logic [1:0] ta, tbv, tc, td,
                            input bit jit, input bit ign_start,
                            input bit ab_idle, input bit ab_done);
      exp_t e;
      e = model(ta, tbv, tc, td);
      sb.push_back(e);
      @(negedge clk);
      a = ta; b = tbv; c = tc; d = td;
      start = 1'b1; abort = ab_idle;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         start = 1'b0; abort = 1'b0;
         chk("busy_run", busy, 1);
         chk("op_cur_seq", op_cur, k);
         chk("done_early", done, 0);
         if (jit) begin
            a = 2'($urandom); b = 2'($urandom);
            c = 2'($urandom); d = 2'($urandom);
         end
         if (ign_start && k == 1) start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      chk("done_latency", done, 1);
      chk("busy_in_done", busy, 0);
      chk("op_cur_done", op_cur, 0);
      if (ab_done) abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("busy_after", busy, 0);
      chk("done_width", done, 0);
      chk("hold_mask", pass_mask, e.mask);
      chk("hold_count", pass_count, e.cnt);
      chk("hold_best", best_op, e.best);
      chk("hold_results", results, e.res);
   endtask

   task automatic check_cleared(input string nm);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_done"}, done, 0);
      chk({nm, "_op_cur"}, op_cur, 0);
      chk({nm, "_mask"}, pass_mask, 0);
      chk({nm, "_count"}, pass_count, 0);
      chk({nm, "_best"}, best_op, 0);
      chk({nm, "_results"}, results, 0);
   endtask

   // abort asserted while op index k is being evaluated (k=3 tests priority over completion)
   task automatic run_abort(input logic [1:0] ta, tbv, tc, td, input int k);
      @(negedge clk);
      a = ta; b = tbv; c = tc; d = td; start = 1'b1;
      for (int i = 0; i <= k; i++) begin
         @(negedge clk);
         start = 1'b0;
         chk("abort_op_cur", op_cur, i);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_cleared("abort");
      repeat (3) begin
         @(negedge clk);
         chk("abort_no_done", done, 0);
      end
   endtask

   task automatic run_reset_mid(input logic [1:0] ta, tbv, tc, td);
      @(negedge clk);
      a = ta; b = tbv; c = tc; d = td; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("rst_op_cur", op_cur, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_cleared("midrst");
      repeat (3) begin
         @(negedge clk);
         chk("midrst_no_done", done, 0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      a = '0; b = '0; c = '0; d = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_cleared("reset");
      rst = 1'b0;

      run_sweep(2'd3, 2'd1, 2'd3, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      run_sweep(2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_sweep(2'd2, 2'd2, 2'd2, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      run_abort(2'd3, 2'd1, 2'd3, 2'd2, 2);
      run_sweep(2'd3, 2'd1, 2'd3, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      run_sweep(2'd1, 2'd2, 2'd3, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1);
      run_abort(2'd0, 2'd1, 2'd2, 2'd0, 3);
      run_reset_mid(2'd3, 2'd3, 2'd3, 2'd1);
      run_sweep(2'd1, 2'd0, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 5) == 0)
            run_abort(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                      int'($urandom_range(0, 3)));
         else
            run_sweep(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                      1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/op_sweep_ctrl.md
Name: op_sweep_ctrl

Overview:
- Sequencer for the 2-bit four-function logic operator and the 2-bit unsigned ">=" comparator.
- On a start request, it latches operands a/b/c and threshold d, then steps the op select through 0..3, one op per cycle.
- Each op result is compared against d. The block reports a per-op pass mask, a pass count and the index of the op giving the largest result.
- Sits between a requester (switch/button front end or test FSM) and the shared op/compare datapath, which is implemented inside this block.

Parameters:
- NUM_OPS, 4, number of ops swept; fixed at 4. Other values unsupported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  sweep request; sampled only in IDLE
- abort  input  1  cancels a sweep in progress; sampled only in RUN
- a  input  2  operand a, latched on accepted start
- b  input  2  operand b, latched on accepted start
- c  input  2  operand c, latched on accepted start
- d  input  2  compare threshold, latched on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when a sweep completes
- op_cur  output  2  op currently being evaluated; 0 when not in RUN
- pass_mask  output  4  bit i = 1 when result of op i >= d
- pass_count  output  3  number of set bits in pass_mask (0..4)
- best_op  output  2  index of op with largest result; ties go to the lowest index
- results  output  8  {r3,r2,r1,r0}; see Optional Feature

Behaviour:
- Op functions, all bitwise on 2 bits:
  - op0: ~(a&b&c)
  - op1: a&b&c
  - op2: ~(a|b|c)
  - op3: a|b|c
- Compare is unsigned: pass when r >= d.
- Reset: state=IDLE; busy=0, done=0, op_cur=0, pass_mask=0, pass_count=0, best_op=0, results=0; operand latches cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge N latches a/b/c/d, clears pass_mask/pass_count/best_op/results, sets op index=0 and goes to RUN.
  - Otherwise stays in IDLE; result outputs hold their last values.
- RUN:
  - One op per cycle: op0 in cycle N+1 through op3 in cycle N+4. busy=1 and op_cur=index.
  - At the end of each RUN cycle: pass_mask[idx] = (r>=d); pass_count increments when the op passes; best_op is updated only if r is strictly greater than the best result so far.
  - Op0 always initialises the running best.
  - After idx=3, go to DONE.
- DONE: done=1 for exactly one cycle (N+5), busy=0; returns to IDLE. Outputs are final and stable from N+5.
- Latency: start accepted at edge N -> done high in cycle N+5. A new start is accepted in cycle N+6 at the earliest.
- start while in RUN or DONE: ignored, not queued.
- abort=1 in RUN:
  - Next state IDLE. No done pulse.
  - pass_mask, pass_count, best_op and results are cleared to 0.
  - abort has priority over completing op3.
- abort in IDLE/DONE: ignored.
- start and abort both high in IDLE: start wins; abort is ignored.
- rst asserted mid-sweep: all outputs return to reset values on the next edge. No done pulse.
- Operand inputs changing during RUN have no effect; only the latched copies are used.
- Arithmetic: all results are 2-bit with no carry. pass_count is 3 bits and never exceeds 4.

Optional Feature:
- Macro: OP_SWEEP_RESULT_LOG_EN.
- Defined: results captures each op's 2-bit result r_i in bits [2i+1:2i] during the RUN cycle for that op. Cleared on accepted start, abort and rst.
- Undefined: no result registers are built and results is tied to 8'h00. All other behaviour is identical.

Test Plan:
- Sweep with mixed passes: rst 2 cycles, then start with a=3,b=1,c=3,d=2 -> done exactly 5 cycles after start. pass_mask=4'b1001, pass_count=3'd2, best_op=2'd3. With the macro defined, results=8'b11_00_01_10.
- Ties on best result: start with a=0,b=0,c=0,d=0 -> pass_mask=4'b1111, pass_count=4, best_op=0 (r0=r2=3). With the macro, results=8'b00_11_00_11.
- No passes: start with a=2,b=2,c=2,d=3 -> pass_mask=4'b0000, pass_count=0, best_op=1. busy high for exactly 4 cycles; op_cur sequence 0,1,2,3.
- Abort and ignored start: start with a=3,b=1,c=3,d=2; assert abort in the 3rd RUN cycle (op_cur=2) -> IDLE next cycle, no done, pass_mask=0, pass_count=0. A start pulse during RUN of a second sweep is ignored and the sweep still ends on schedule.
- Mid-sweep reset and operand stability: rst asserted while op_cur=1 -> all outputs 0 next cycle, no done. Then restart, change a/b/c/d every cycle during RUN -> results match the values latched at start.
